// File: rtl/vi_pkg.sv
// -----------------------------------------------------------------------------
// vi_pkg
// Shared definitions for the integer multiply pipeline (int_mult_pipe).
//   - MULT_FUNCT_* : 2-bit multiply function codes carried with each op
//   - XLEN_DEF / REG_AW_DEF : default operand and register-address widths
//   - mult_sel_hi()   : 1 when the function returns the high product half
//   - mult_a_signed() : 1 when rs1 is treated as a signed operand
//   - mult_b_signed() : 1 when rs2 is treated as a signed operand
// -----------------------------------------------------------------------------
package vi_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] MULT_FUNCT_MUL    = 2'd0;
    localparam logic [1:0] MULT_FUNCT_MULH   = 2'd1;
    localparam logic [1:0] MULT_FUNCT_MULHSU = 2'd2;
    localparam logic [1:0] MULT_FUNCT_MULHU  = 2'd3;

    // MUL returns the low half; every MULH variant returns the high half.
    function automatic logic mult_sel_hi(input logic [1:0] funct);
        logic sel_hi;
        case (funct)
            MULT_FUNCT_MUL:    sel_hi = 1'b0;
            MULT_FUNCT_MULH:   sel_hi = 1'b1;
            MULT_FUNCT_MULHSU: sel_hi = 1'b1;
            MULT_FUNCT_MULHU:  sel_hi = 1'b1;
            default:           sel_hi = 1'b0;
        endcase
        return sel_hi;
    endfunction

    // rs1 is signed for MUL, MULH and MULHSU.
    function automatic logic mult_a_signed(input logic [1:0] funct);
        logic sgn;
        case (funct)
            MULT_FUNCT_MUL:    sgn = 1'b1;
            MULT_FUNCT_MULH:   sgn = 1'b1;
            MULT_FUNCT_MULHSU: sgn = 1'b1;
            MULT_FUNCT_MULHU:  sgn = 1'b0;
            default:           sgn = 1'b0;
        endcase
        return sgn;
    endfunction

    // rs2 is signed only for MUL and MULH.
    function automatic logic mult_b_signed(input logic [1:0] funct);
        logic sgn;
        case (funct)
            MULT_FUNCT_MUL:    sgn = 1'b1;
            MULT_FUNCT_MULH:   sgn = 1'b1;
            MULT_FUNCT_MULHSU: sgn = 1'b0;
            MULT_FUNCT_MULHU:  sgn = 1'b0;
            default:           sgn = 1'b0;
        endcase
        return sgn;
    endfunction

endpackage

// File: rtl/int_mult_stage.sv
// -----------------------------------------------------------------------------
// int_mult_stage
// One register slice of the multiply pipeline. Loads the previous stage on
// advance, holds otherwise; kill clears the valid bit (payload may go stale).
// Ports:
//   clk_i, rsn_i          clock, async active-low reset
//   advance_i             whole pipe moves this edge
//   kill_i                flush: clear valid, overrides advance
//   valid_i..pc_i         previous stage contents
//   valid_o..pc_o         this stage's registered contents
// -----------------------------------------------------------------------------
module int_mult_stage
    import vi_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              advance_i,
    input  logic              kill_i,
    input  logic              valid_i,
    input  logic [1:0]        funct_i,
    input  logic [2*XLEN-1:0] prod_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [31:0]       instr_i,
    input  logic [31:0]       pc_i,
    output logic              valid_o,
    output logic [1:0]        funct_o,
    output logic [2*XLEN-1:0] prod_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o
);

    logic              valid_q, valid_d;
    logic [1:0]        funct_q, funct_d;
    logic [2*XLEN-1:0] prod_q,  prod_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       pc_q,    pc_d;

    // Next-state: kill beats advance for the valid bit; payload follows advance.
    always_comb begin
        valid_d = valid_q;
        funct_d = funct_q;
        prod_d  = prod_q;
        rd_d    = rd_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (kill_i) begin
            valid_d = 1'b0;
        end else if (advance_i) begin
            valid_d = valid_i;
        end else begin
            valid_d = valid_q;
        end
        if (advance_i) begin
            funct_d = funct_i;
            prod_d  = prod_i;
            rd_d    = rd_i;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else begin
            funct_d = funct_q;
            prod_d  = prod_q;
            rd_d    = rd_q;
            instr_d = instr_q;
            pc_d    = pc_q;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            valid_q <= 1'b0;
            funct_q <= 2'd0;
            prod_q  <= '0;
            rd_q    <= '0;
            instr_q <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            valid_q <= valid_d;
            funct_q <= funct_d;
            prod_q  <= prod_d;
            rd_q    <= rd_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign funct_o = funct_q;
    assign prod_o  = prod_q;
    assign rd_o    = rd_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/int_mult_pipe.sv
// -----------------------------------------------------------------------------
// int_mult_pipe
// Parametrised integer multiply pipeline (MUL/MULH/MULHSU/MULHU). An accepted
// op reaches the writeback port DEPTH cycles later; all stages move in lockstep
// (bubbles are kept), stall or an unaccepted result holds the whole pipe, and
// kill flushes every in-flight op. Destination registers of in-flight ops are
// compared against two decode queries to raise hazards for bypass control.
//
// Optional feature macro: VI_MULT_FWD_EN
//   defined   : a query whose youngest matching op sits in the final stage is
//               forwarded (fwd_x_valid_o=1, hazard_x_o=0, fwd_data_o=wb_data_o)
//   undefined : fwd_*_valid_o and fwd_data_o tied 0; any match is a hazard
//
// Parameters: DEPTH (2..8), XLEN, REG_AW
// Ports:
//   clk_i, rsn_i                  clock, async active-low reset
//   stall_i, kill_i               hold all stages / flush all stages
//   issue_*                       op in (valid/ready handshake)
//   read_addr_a_i/_b_i            decode source-register queries
//   hazard_a_o/_b_o               query hits an in-flight op
//   fwd_a_valid_o/_b_valid_o      query served from final stage
//   fwd_data_o                    final-stage result
//   busy_o                        any stage valid
//   wb_*                          result out (valid/ready handshake)
// -----------------------------------------------------------------------------
module int_mult_pipe
    import vi_pkg::*;
#(
    parameter int DEPTH  = 5,
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk_i,
    input  logic              rsn_i,
    input  logic              stall_i,
    input  logic              kill_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [1:0]        issue_funct_i,
    input  logic [XLEN-1:0]   issue_data_a_i,
    input  logic [XLEN-1:0]   issue_data_b_i,
    input  logic [REG_AW-1:0] issue_write_addr_i,
    input  logic [31:0]       issue_instr_i,
    input  logic [31:0]       issue_pc_i,
    input  logic [REG_AW-1:0] read_addr_a_i,
    input  logic [REG_AW-1:0] read_addr_b_i,
    output logic              hazard_a_o,
    output logic              hazard_b_o,
    output logic              fwd_a_valid_o,
    output logic              fwd_b_valid_o,
    output logic [XLEN-1:0]   fwd_data_o,
    output logic              busy_o,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [REG_AW-1:0] wb_write_addr_o,
    output logic [31:0]       wb_instr_o,
    output logic [31:0]       wb_pc_o
);

    // Per-stage views, index 1 = youngest, DEPTH = writeback stage.
    logic              stg_valid_s [1:DEPTH];
    logic [1:0]        stg_funct_s [1:DEPTH];
    logic [2*XLEN-1:0] stg_prod_s  [1:DEPTH];
    logic [REG_AW-1:0] stg_rd_s    [1:DEPTH];
    logic [31:0]       stg_instr_s [1:DEPTH];
    logic [31:0]       stg_pc_s    [1:DEPTH];

    logic              advance_s;
    logic              a_sign_s;
    logic              b_sign_s;
    logic [2*XLEN-1:0] op_a_s;
    logic [2*XLEN-1:0] op_b_s;
    logic [2*XLEN-1:0] prod_s;
    logic              busy_s;
    logic [XLEN-1:0]   wb_data_s;
    logic [DEPTH:1]    match_a_s;
    logic [DEPTH:1]    match_b_s;

    logic              stg1_valid_q, stg1_valid_d;
    logic [1:0]        stg1_funct_q, stg1_funct_d;
    logic [2*XLEN-1:0] stg1_prod_q,  stg1_prod_d;
    logic [REG_AW-1:0] stg1_rd_q,    stg1_rd_d;
    logic [31:0]       stg1_instr_q, stg1_instr_d;
    logic [31:0]       stg1_pc_q,    stg1_pc_d;

    // The pipe moves only when not stalled and the final stage is empty or draining.
    assign advance_s     = !stall_i && (!stg_valid_s[DEPTH] || wb_ready_i);
    assign issue_ready_o = advance_s;

    // Full-width product: operands are sign- or zero-extended to 2*XLEN, so the
    // low 2*XLEN bits of the unsigned product equal the mixed-sign product.
    always_comb begin
        a_sign_s = mult_a_signed(issue_funct_i) & issue_data_a_i[XLEN-1];
        b_sign_s = mult_b_signed(issue_funct_i) & issue_data_b_i[XLEN-1];
        op_a_s   = {{XLEN{a_sign_s}}, issue_data_a_i};
        op_b_s   = {{XLEN{b_sign_s}}, issue_data_b_i};
        prod_s   = op_a_s * op_b_s;
    end

    // Stage-1 next state: kill clears valid even when an issue is presented.
    always_comb begin
        stg1_valid_d = stg1_valid_q;
        stg1_funct_d = stg1_funct_q;
        stg1_prod_d  = stg1_prod_q;
        stg1_rd_d    = stg1_rd_q;
        stg1_instr_d = stg1_instr_q;
        stg1_pc_d    = stg1_pc_q;
        if (kill_i) begin
            stg1_valid_d = 1'b0;
        end else if (advance_s) begin
            stg1_valid_d = issue_valid_i;
        end else begin
            stg1_valid_d = stg1_valid_q;
        end
        if (advance_s) begin
            stg1_funct_d = issue_funct_i;
            stg1_prod_d  = prod_s;
            stg1_rd_d    = issue_write_addr_i;
            stg1_instr_d = issue_instr_i;
            stg1_pc_d    = issue_pc_i;
        end else begin
            stg1_funct_d = stg1_funct_q;
            stg1_prod_d  = stg1_prod_q;
            stg1_rd_d    = stg1_rd_q;
            stg1_instr_d = stg1_instr_q;
            stg1_pc_d    = stg1_pc_q;
        end
    end

    // Stage-1 register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            stg1_valid_q <= 1'b0;
            stg1_funct_q <= 2'd0;
            stg1_prod_q  <= '0;
            stg1_rd_q    <= '0;
            stg1_instr_q <= 32'd0;
            stg1_pc_q    <= 32'd0;
        end else begin
            stg1_valid_q <= stg1_valid_d;
            stg1_funct_q <= stg1_funct_d;
            stg1_prod_q  <= stg1_prod_d;
            stg1_rd_q    <= stg1_rd_d;
            stg1_instr_q <= stg1_instr_d;
            stg1_pc_q    <= stg1_pc_d;
        end
    end

    assign stg_valid_s[1] = stg1_valid_q;
    assign stg_funct_s[1] = stg1_funct_q;
    assign stg_prod_s[1]  = stg1_prod_q;
    assign stg_rd_s[1]    = stg1_rd_q;
    assign stg_instr_s[1] = stg1_instr_q;
    assign stg_pc_s[1]    = stg1_pc_q;

    for (genvar k = 2; k <= DEPTH; k++) begin : g_stage
        int_mult_stage #(
            .XLEN   (XLEN),
            .REG_AW (REG_AW)
        ) u_stage (
            .clk_i     (clk_i),
            .rsn_i     (rsn_i),
            .advance_i (advance_s),
            .kill_i    (kill_i),
            .valid_i   (stg_valid_s[k-1]),
            .funct_i   (stg_funct_s[k-1]),
            .prod_i    (stg_prod_s[k-1]),
            .rd_i      (stg_rd_s[k-1]),
            .instr_i   (stg_instr_s[k-1]),
            .pc_i      (stg_pc_s[k-1]),
            .valid_o   (stg_valid_s[k]),
            .funct_o   (stg_funct_s[k]),
            .prod_o    (stg_prod_s[k]),
            .rd_o      (stg_rd_s[k]),
            .instr_o   (stg_instr_s[k]),
            .pc_o      (stg_pc_s[k])
        );
    end

    // Busy whenever any stage carries a live op.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            busy_s = busy_s | stg_valid_s[k];
        end
    end

    // Final-stage result select: MUL takes the low half, MULH* the high half.
    always_comb begin
        if (mult_sel_hi(stg_funct_s[DEPTH])) begin
            wb_data_s = stg_prod_s[DEPTH][2*XLEN-1:XLEN];
        end else begin
            wb_data_s = stg_prod_s[DEPTH][XLEN-1:0];
        end
    end

    // Per-stage destination match; x0 is never a dependency.
    always_comb begin
        match_a_s = '0;
        match_b_s = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match_a_s[k] = stg_valid_s[k] && (stg_rd_s[k] == read_addr_a_i) && (read_addr_a_i != '0);
            match_b_s[k] = stg_valid_s[k] && (stg_rd_s[k] == read_addr_b_i) && (read_addr_b_i != '0);
        end
    end

`ifdef VI_MULT_FWD_EN
    // A younger match shadows the final stage: its value is not yet computed,
    // so only a final-stage-only match can be forwarded.
    assign hazard_a_o    = |match_a_s[DEPTH-1:1];
    assign hazard_b_o    = |match_b_s[DEPTH-1:1];
    assign fwd_a_valid_o = match_a_s[DEPTH] && !(|match_a_s[DEPTH-1:1]);
    assign fwd_b_valid_o = match_b_s[DEPTH] && !(|match_b_s[DEPTH-1:1]);
    assign fwd_data_o    = wb_data_s;
`else
    assign hazard_a_o    = |match_a_s;
    assign hazard_b_o    = |match_b_s;
    assign fwd_a_valid_o = 1'b0;
    assign fwd_b_valid_o = 1'b0;
    assign fwd_data_o    = '0;
`endif

    assign busy_o          = busy_s;
    assign wb_valid_o      = stg_valid_s[DEPTH];
    assign wb_data_o       = wb_data_s;
    assign wb_write_addr_o = stg_rd_s[DEPTH];
    assign wb_instr_o      = stg_instr_s[DEPTH];
    assign wb_pc_o         = stg_pc_s[DEPTH];

endmodule

// File: tb/tb_int_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_int_mult_pipe
// Self-checking bench for int_mult_pipe (DEPTH=5, XLEN=32, REG_AW=5): a table
// of directed multiplies, hand-written stall/hazard/kill/reset sequences, and a
// randomized run checked against a behavioural model of the pipe.
// -----------------------------------------------------------------------------
module tb_int_mult_pipe;

    localparam int DEPTH  = 5;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk_i = 1'b0;
    logic              rsn_i = 1'b0;
    logic              stall_i = 1'b0;
    logic              kill_i = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic              issue_ready_o;
    logic [1:0]        issue_funct_i = 2'd0;
    logic [XLEN-1:0]   issue_data_a_i = '0;
    logic [XLEN-1:0]   issue_data_b_i = '0;
    logic [REG_AW-1:0] issue_write_addr_i = '0;
    logic [31:0]       issue_instr_i = 32'd0;
    logic [31:0]       issue_pc_i = 32'd0;
    logic [REG_AW-1:0] read_addr_a_i = '0;
    logic [REG_AW-1:0] read_addr_b_i = '0;
    logic              hazard_a_o, hazard_b_o;
    logic              fwd_a_valid_o, fwd_b_valid_o;
    logic [XLEN-1:0]   fwd_data_o;
    logic              busy_o;
    logic              wb_valid_o;
    logic              wb_ready_i = 1'b1;
    logic [XLEN-1:0]   wb_data_o;
    logic [REG_AW-1:0] wb_write_addr_o;
    logic [31:0]       wb_instr_o;
    logic [31:0]       wb_pc_o;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_i = ~clk_i;

    int_mult_pipe #(
        .DEPTH  (DEPTH),
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) dut (
        .clk_i              (clk_i),
        .rsn_i              (rsn_i),
        .stall_i            (stall_i),
        .kill_i             (kill_i),
        .issue_valid_i      (issue_valid_i),
        .issue_ready_o      (issue_ready_o),
        .issue_funct_i      (issue_funct_i),
        .issue_data_a_i     (issue_data_a_i),
        .issue_data_b_i     (issue_data_b_i),
        .issue_write_addr_i (issue_write_addr_i),
        .issue_instr_i      (issue_instr_i),
        .issue_pc_i         (issue_pc_i),
        .read_addr_a_i      (read_addr_a_i),
        .read_addr_b_i      (read_addr_b_i),
        .hazard_a_o         (hazard_a_o),
        .hazard_b_o         (hazard_b_o),
        .fwd_a_valid_o      (fwd_a_valid_o),
        .fwd_b_valid_o      (fwd_b_valid_o),
        .fwd_data_o         (fwd_data_o),
        .busy_o             (busy_o),
        .wb_valid_o         (wb_valid_o),
        .wb_ready_i         (wb_ready_i),
        .wb_data_o          (wb_data_o),
        .wb_write_addr_o    (wb_write_addr_o),
        .wb_instr_o         (wb_instr_o),
        .wb_pc_o            (wb_pc_o)
    );

    typedef struct {
        logic [1:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        bit          valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] instr;
        logic [31:0] pc;
    } slot_t;

    vec_t  vecs [8];
    slot_t pipe [DEPTH];   // pipe[0] = youngest stage, pipe[DEPTH-1] = writeback

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference: unsigned product, then correct the high word for signed operands.
    function automatic logic [31:0] ref_mult(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] pu;
        logic [31:0] hi;
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32];
        if (f != 2'd3 && a[31]) hi = hi - b;
        if (f <= 2'd1 && b[31]) hi = hi - a;
        return (f == 2'd0) ? pu[31:0] : hi;
    endfunction

    task automatic drive_issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] rd, input logic [31:0] instr, input logic [31:0] pc);
        issue_valid_i      = 1'b1;
        issue_funct_i      = f;
        issue_data_a_i     = a;
        issue_data_b_i     = b;
        issue_write_addr_i = rd;
        issue_instr_i      = instr;
        issue_pc_i         = pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 32'd7,        32'hFFFF_FFFD, 5'd4,  32'hFFFF_FFEB};
        vecs[1] = '{2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6,  32'h0000_0000};
        vecs[2] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7,  32'h8000_0000};
        vecs[3] = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h7FFF_FFFF};
        vecs[4] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000};
        vecs[5] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE};
        vecs[6] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0000_0000};
        vecs[7] = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'd31, 32'hFFFF_FFFF};

        // Reset state, sampled mid-cycle while rsn_i is low
        #12;
        chk("rst_issue_ready", issue_ready_o, 1);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_wb_rd", wb_write_addr_o, 0);
        chk("rst_wb_instr", wb_instr_o, 0);
        chk("rst_wb_pc", wb_pc_o, 0);
        chk("rst_hazard", {hazard_a_o, hazard_b_o, fwd_a_valid_o, fwd_b_valid_o}, 0);
        chk("rst_fwd_data", fwd_data_o, 0);
        #11;
        rsn_i = 1'b1;
        tick();

        // T1/T2 table: issue in cycle 0, result in cycle DEPTH
        for (int i = 0; i < 8; i++) begin
            drive_issue(vecs[i].funct, vecs[i].a, vecs[i].b, vecs[i].rd,
                        32'h1000_0000 + i, 32'h0000_4000 + 32'(i * 4));
            settle();
            chk("tbl_issue_ready", issue_ready_o, 1);
            tick();
            issue_valid_i = 1'b0;
            for (int c = 1; c < DEPTH; c++) begin
                settle();
                if (c == DEPTH - 1) chk("tbl_early_wb", wb_valid_o, 0);
                tick();
            end
            settle();
            chk("tbl_wb_valid", wb_valid_o, 1);
            chk("tbl_wb_data", wb_data_o, vecs[i].exp);
            chk("tbl_wb_rd", wb_write_addr_o, vecs[i].rd);
            chk("tbl_wb_instr", wb_instr_o, 32'h1000_0000 + i);
            chk("tbl_wb_pc", wb_pc_o, 32'h0000_4000 + 32'(i * 4));
            tick();
            settle();
            chk("tbl_drained", {busy_o, wb_valid_o}, 0);
        end

        // T3: back-to-back rd=1..5, writeback refuses in cycle 5
        tick();
        for (int c = 0; c < 5; c++) begin
            drive_issue(2'd0, 32'(c + 1), 32'd10, 5'(c + 1), 32'h2000_0000, 32'h0000_8000);
            settle();
            chk("t3_issue_ready", issue_ready_o, 1);
            tick();
        end
        issue_valid_i = 1'b0;
        wb_ready_i    = 1'b0;
        settle();
        chk("t3_c5_wb_valid", wb_valid_o, 1);
        chk("t3_c5_wb_rd", wb_write_addr_o, 1);
        chk("t3_c5_ready_low", issue_ready_o, 0);
        tick();
        wb_ready_i = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            settle();
            chk("t3_wb_valid", wb_valid_o, 1);
            chk("t3_wb_rd", wb_write_addr_o, j);
            chk("t3_wb_data", wb_data_o, j * 10);
            tick();
        end
        settle();
        chk("t3_done", wb_valid_o, 0);
        tick();

        // T4: dependency on rd=3 through the pipe
        drive_issue(2'd0, 32'd6, 32'd7, 5'd3, 32'h3000_0000, 32'h0000_C000);
        read_addr_a_i = 5'd3;
        read_addr_b_i = 5'd0;
        settle();
        chk("t4_c0_no_hazard", hazard_a_o, 0);
        tick();
        issue_valid_i = 1'b0;
        for (int c = 1; c < DEPTH; c++) begin
            settle();
            chk("t4_hazard_a", hazard_a_o, 1);
            chk("t4_fwd_a", fwd_a_valid_o, 0);
            chk("t4_hazard_b_x0", hazard_b_o, 0);
            tick();
        end
        settle();
`ifdef VI_MULT_FWD_EN
        chk("t4_final_hazard", hazard_a_o, 0);
        chk("t4_final_fwd", fwd_a_valid_o, 1);
        chk("t4_fwd_data", fwd_data_o, 42);
`else
        chk("t4_final_hazard", hazard_a_o, 1);
        chk("t4_final_fwd", fwd_a_valid_o, 0);
        chk("t4_fwd_data", fwd_data_o, 0);
`endif
        tick();
        settle();
        chk("t4_cleared", hazard_a_o, 0);
        read_addr_a_i = 5'd0;
        tick();

        // T5: kill with a same-cycle issue
        for (int c = 0; c < 3; c++) begin
            drive_issue(2'd0, 32'd3, 32'(c), 5'(c + 12), 32'h5000_0000, 32'h0001_0000);
            kill_i = (c == 2);
            settle();
            if (c == 2) chk("t5_busy_before_kill", busy_o, 1);
            tick();
        end
        kill_i        = 1'b0;
        issue_valid_i = 1'b0;
        for (int c = 3; c < 11; c++) begin
            settle();
            chk("t5_busy", busy_o, 0);
            chk("t5_no_wb", wb_valid_o, 0);
            tick();
        end

        // T6: asynchronous reset mid-stream, then an rd=0 op
        for (int c = 0; c < 3; c++) begin
            drive_issue(2'd0, 32'd9, 32'd9, 5'd20, 32'h6000_0000, 32'h0002_0000);
            read_addr_a_i = 5'd20;
            tick();
        end
        settle();
        chk("t6_busy_pre", busy_o, 1);
        chk("t6_hazard_pre", hazard_a_o, 1);
        #1;
        rsn_i = 1'b0;
        #1;
        chk("t6_busy", busy_o, 0);
        chk("t6_hazard", hazard_a_o, 0);
        chk("t6_issue_ready", issue_ready_o, 1);
        chk("t6_wb", {wb_valid_o, wb_data_o, wb_write_addr_o}, 0);
        chk("t6_wb_meta", {wb_instr_o, wb_pc_o}, 0);
        #2;
        rsn_i = 1'b1;
        tick();
        drive_issue(2'd0, 32'd5, 32'd6, 5'd0, 32'h6100_0000, 32'h0003_0000);
        read_addr_a_i = 5'd0;
        read_addr_b_i = 5'd0;
        tick();
        issue_valid_i = 1'b0;
        for (int c = 1; c <= DEPTH; c++) begin
            settle();
            chk("t6_x0_hazard", {hazard_a_o, hazard_b_o, fwd_a_valid_o, fwd_b_valid_o}, 0);
            if (c == DEPTH) begin
                chk("t6_x0_wb_valid", wb_valid_o, 1);
                chk("t6_x0_wb_data", wb_data_o, 30);
                chk("t6_x0_wb_rd", wb_write_addr_o, 0);
            end
            tick();
        end

        // Randomized run against the behavioural model (pipe is empty here)
        for (int k = 0; k < DEPTH; k++) pipe[k].valid = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic exp_adv;
            logic exp_busy;
            logic haz_a, haz_b, fwd_a, fwd_b;
            logic [31:0] ra, rb;
            bit found_a, found_b;

            stall_i            = ($urandom_range(0, 9) == 0);
            wb_ready_i         = ($urandom_range(0, 3) != 0);
            kill_i             = ($urandom_range(0, 39) == 0);
            issue_valid_i      = ($urandom_range(0, 2) != 0);
            issue_funct_i      = 2'($urandom_range(0, 3));
            ra                 = $urandom;
            rb                 = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
            issue_data_a_i     = ra;
            issue_data_b_i     = rb;
            issue_write_addr_i = 5'($urandom_range(0, 3));
            issue_instr_i      = $urandom;
            issue_pc_i         = $urandom;
            read_addr_a_i      = 5'($urandom_range(0, 3));
            read_addr_b_i      = 5'($urandom_range(0, 3));
            settle();

            exp_adv  = !stall_i && (!pipe[DEPTH-1].valid || wb_ready_i);
            exp_busy = 1'b0;
            for (int k = 0; k < DEPTH; k++) exp_busy |= pipe[k].valid;
            chk("rnd_issue_ready", issue_ready_o, exp_adv);
            chk("rnd_busy", busy_o, exp_busy);
            chk("rnd_wb_valid", wb_valid_o, pipe[DEPTH-1].valid);
            if (pipe[DEPTH-1].valid) begin
                chk("rnd_wb_data", wb_data_o, pipe[DEPTH-1].data);
                chk("rnd_wb_rd", wb_write_addr_o, pipe[DEPTH-1].rd);
                chk("rnd_wb_instr", wb_instr_o, pipe[DEPTH-1].instr);
                chk("rnd_wb_pc", wb_pc_o, pipe[DEPTH-1].pc);
            end

            // The youngest in-flight writer of the queried register decides.
            haz_a = 1'b0; fwd_a = 1'b0; found_a = 0;
            haz_b = 1'b0; fwd_b = 1'b0; found_b = 0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found_a && pipe[k].valid && read_addr_a_i != 5'd0 && pipe[k].rd == read_addr_a_i) begin
                    found_a = 1;
`ifdef VI_MULT_FWD_EN
                    if (k == DEPTH - 1) fwd_a = 1'b1; else haz_a = 1'b1;
`else
                    haz_a = 1'b1;
`endif
                end
                if (!found_b && pipe[k].valid && read_addr_b_i != 5'd0 && pipe[k].rd == read_addr_b_i) begin
                    found_b = 1;
`ifdef VI_MULT_FWD_EN
                    if (k == DEPTH - 1) fwd_b = 1'b1; else haz_b = 1'b1;
`else
                    haz_b = 1'b1;
`endif
                end
            end
            chk("rnd_hazard_a", hazard_a_o, haz_a);
            chk("rnd_hazard_b", hazard_b_o, haz_b);
            chk("rnd_fwd_a", fwd_a_valid_o, fwd_a);
            chk("rnd_fwd_b", fwd_b_valid_o, fwd_b);
`ifdef VI_MULT_FWD_EN
            if (fwd_a || fwd_b) chk("rnd_fwd_data", fwd_data_o, pipe[DEPTH-1].data);
`else
            chk("rnd_fwd_data", fwd_data_o, 0);
`endif

            // Model update for the coming edge
            if (kill_i) begin
                for (int k = 0; k < DEPTH; k++) pipe[k].valid = 1'b0;
            end else if (exp_adv) begin
                for (int k = DEPTH - 1; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0].valid = issue_valid_i;
                pipe[0].data  = ref_mult(issue_funct_i, ra, rb);
                pipe[0].rd    = issue_write_addr_i;
                pipe[0].instr = issue_instr_i;
                pipe[0].pc    = issue_pc_i;
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
